// File: rtl/fetch_unit_pkg.sv
// Shared widths, constants and FSM state type for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // addi x0,x0,0 -- what decode sees whenever no fetched word is valid
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD
  } fetchState_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory handshake plus the decode-side instruction/redirect/stall
// signals of the fetch stage, bundled so the top only carries clk/rst scalars.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic            IMEM_REQ;
  logic [XLEN-1:0] IMEM_ADDR;
  logic            IMEM_GNT;
  logic            IMEM_RVALID;
  logic [XLEN-1:0] IMEM_RDATA;
  logic            REDIRECT;
  logic [XLEN-1:0] REDIRECT_PC;
  logic            STALL;
  logic [XLEN-1:0] INSTR;
  logic [XLEN-1:0] INSTR_PC;
  logic            INSTR_VALID;

  // The fetch unit itself
  modport master (
    output IMEM_REQ, IMEM_ADDR, INSTR, INSTR_PC, INSTR_VALID,
    input  IMEM_GNT, IMEM_RVALID, IMEM_RDATA, REDIRECT, REDIRECT_PC, STALL
  );

  // Memory and decode surrounding the fetch unit
  modport slave (
    input  IMEM_REQ, IMEM_ADDR, INSTR, INSTR_PC, INSTR_VALID,
    output IMEM_GNT, IMEM_RVALID, IMEM_RDATA, REDIRECT, REDIRECT_PC, STALL
  );

endinterface

// File: rtl/fetch_unit_instr_skid_buf.sv
// Single-entry holding register for a fetched word that arrived while decode
// was stalled and the output register was still occupied.
module instr_skid_buf
  import fetch_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] data_o,
  output logic [XLEN-1:0] pc_o,
  output logic            valid_o
);

  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] pc_q;
  logic            valid_q;

  // Capture on load, empty on pop; a flush (redirect) beats everything
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one memory request at a time,
// and presents each fetched word with its PC to decode, honouring stall and
// branch/jump redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic          CLK,
  input logic          RST,
  fetch_unit_if.master bus
);

  fetchState_e     state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetchPc_q, fetchPc_d;
  logic            drop_q, drop_d;
  logic            started_q;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instrPc_q, instrPc_d;
  logic            instrValid_q, instrValid_d;

  logic            skidLoad, skidPop, skidFlush;
  logic [XLEN-1:0] skidData, skidPc;
  logic            skidValid;

  logic            imemReq;
  logic            granted;
  logic            consume;

  instr_skid_buf u_skid (
    .clk_i   (CLK),
    .rst_i   (RST),
    .load_i  (skidLoad),
    .pop_i   (skidPop),
    .flush_i (skidFlush),
    .data_i  (bus.IMEM_RDATA),
    .pc_i    (fetchPc_q),
    .data_o  (skidData),
    .pc_o    (skidPc),
    .valid_o (skidValid)
  );

  // started_q keeps the request low until the first edge after reset release
  assign imemReq = started_q && (state_q == FETCH) && !(instrValid_q && skidValid);
  assign granted = imemReq && bus.IMEM_GNT;
  assign consume = instrValid_q && !bus.STALL;

  // Next-state logic; a redirect overrides every other event in the cycle.
  // A redirect in WAIT that coincides with the response consumes that response,
  // so nothing remains in flight and the FSM goes straight back to FETCH.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetchPc_d    = fetchPc_q;
    drop_d       = drop_q;
    instr_d      = instr_q;
    instrPc_d    = instrPc_q;
    instrValid_d = instrValid_q;
    skidLoad     = 1'b0;
    skidPop      = 1'b0;
    skidFlush    = 1'b0;

    if (consume) begin
      instrValid_d = 1'b0;
      instr_d      = NOP_INSTR;
    end

    if (bus.REDIRECT) begin
      pc_d         = bus.REDIRECT_PC & ~XLEN'(3);
      instrValid_d = 1'b0;
      instr_d      = NOP_INSTR;
      skidFlush    = 1'b1;
      if ((state_q == WAIT && !bus.IMEM_RVALID) || granted) begin
        drop_d  = 1'b1;
        state_d = WAIT;
      end else begin
        drop_d  = 1'b0;
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (granted) begin
            pc_d      = pc_q + XLEN'(4);
            fetchPc_d = pc_q;
            state_d   = WAIT;
          end
        end
        WAIT: begin
          if (bus.IMEM_RVALID) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = FETCH;
            end else if (!instrValid_q || consume) begin
              instr_d      = bus.IMEM_RDATA;
              instrPc_d    = fetchPc_q;
              instrValid_d = 1'b1;
              state_d      = FETCH;
            end else begin
              skidLoad = 1'b1;
              state_d  = HOLD;
            end
          end
        end
        HOLD: begin
          if (!bus.STALL) begin
            instr_d      = skidData;
            instrPc_d    = skidPc;
            instrValid_d = 1'b1;
            skidPop      = 1'b1;
            state_d      = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State, PC and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      fetchPc_q    <= RESET_PC;
      drop_q       <= 1'b0;
      started_q    <= 1'b0;
      instr_q      <= NOP_INSTR;
      instrPc_q    <= '0;
      instrValid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetchPc_q    <= fetchPc_d;
      drop_q       <= drop_d;
      started_q    <= 1'b1;
      instr_q      <= instr_d;
      instrPc_q    <= instrPc_d;
      instrValid_q <= instrValid_d;
    end
  end

  assign bus.IMEM_REQ    = imemReq;
  assign bus.IMEM_ADDR   = pc_q;
  assign bus.INSTR       = instr_q;
  assign bus.INSTR_PC    = instrPc_q;
  assign bus.INSTR_VALID = instrValid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: the stimulus process plays instruction
// memory and decode, pushing every word decode should eventually receive
// into a queue; a negedge monitor pops and compares whenever a word is consumed.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] LW_WORD  = {12'b010000100011, 5'b10101, 3'b010, 5'b01010, 7'b0000011};
  localparam logic [31:0] SW_WORD  = 32'h0062_A423;
  localparam logic [31:0] BEQ_WORD = 32'h0062_8463;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } expItem_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC_DEFAULT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int consumed = 0;

  // stimulus knobs (percent probabilities, latency range)
  int gntPct, stallPct, redirPct, strayPct, minLat, maxLat;

  // reference model state
  expItem_t    expQ[$];
  bit          outstanding = 1'b0;
  bit          outStale = 1'b0;
  logic [31:0] outAddr = '0;
  logic [31:0] modelPc = RESET_PC_DEFAULT;
  int          latCnt = 0;
  int          stallLeft = 0;

  // monitor state
  bit          prevRedir = 1'b0;
  bit          prevHeld = 1'b0;
  logic [31:0] heldInstr = '0;
  logic [31:0] heldPc = '0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Contents of instruction memory as seen by the bench
  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0000_0000: return LW_WORD;
      32'h0000_0004: return SW_WORD;
      32'h0000_0008: return BEQ_WORD;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  function automatic logic [31:0] pickRedirectPc();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0103;
      1:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      2:       return $urandom;
      default: return 32'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic checkResetValues();
    checkOutput("rst_req",   {31'b0, bus.IMEM_REQ}, 32'd0);
    checkOutput("rst_addr",  bus.IMEM_ADDR, RESET_PC_DEFAULT);
    checkOutput("rst_instr", bus.INSTR, NOP_INSTR);
    checkOutput("rst_pc",    bus.INSTR_PC, 32'd0);
    checkOutput("rst_valid", {31'b0, bus.INSTR_VALID}, 32'd0);
  endtask

  // One clock of memory/decode behaviour plus reference-model bookkeeping
  task automatic applyStimulus();
    bit          doRedir;
    bit          wasOut;
    logic [31:0] rpc;
    logic [31:0] word;
    @(posedge CLK);
    #1;
    bus.IMEM_GNT    = 1'b0;
    bus.IMEM_RVALID = 1'b0;
    bus.IMEM_RDATA  = $urandom;
    bus.REDIRECT    = 1'b0;
    bus.REDIRECT_PC = $urandom;
    wasOut = outstanding;
    if (wasOut) checkOutput("no_req_while_waiting", {31'b0, bus.IMEM_REQ}, 32'd0);
    if (expQ.size() >= 2) checkOutput("no_req_when_full", {31'b0, bus.IMEM_REQ}, 32'd0);
    if (expQ.size() > 2) checkOutput("held_words_max_two", expQ.size(), 32'd2);
    doRedir = ($urandom_range(0, 99) < redirPct);
    if (wasOut) begin
      latCnt--;
      if (latCnt == 0) begin
        word = memWord(outAddr);
        bus.IMEM_RVALID = 1'b1;
        bus.IMEM_RDATA  = word;
        outstanding = 1'b0;
        if (!outStale && !doRedir) expQ.push_back({word, outAddr});
      end
    end else if ($urandom_range(0, 99) < strayPct) begin
      bus.IMEM_RVALID = 1'b1;
    end
    if ($urandom_range(0, 99) < gntPct) bus.IMEM_GNT = 1'b1;
    if (bus.IMEM_GNT && bus.IMEM_REQ) begin
      checkOutput("fetch_addr", bus.IMEM_ADDR, modelPc);
      outstanding = 1'b1;
      outStale    = doRedir;
      outAddr     = modelPc;
      latCnt      = $urandom_range(minLat, maxLat);
      modelPc     = modelPc + 32'd4;
    end
    if (doRedir) begin
      rpc = pickRedirectPc();
      bus.REDIRECT    = 1'b1;
      bus.REDIRECT_PC = rpc;
      modelPc  = rpc & 32'hFFFF_FFFC;
      outStale = 1'b1;
      expQ.delete();
    end
    if (stallLeft > 0) begin
      bus.STALL = 1'b1;
      stallLeft--;
    end else if ($urandom_range(0, 99) < stallPct) begin
      bus.STALL = 1'b1;
      stallLeft = $urandom_range(0, 5);
    end else begin
      bus.STALL = 1'b0;
    end
  endtask

  // Decode-side monitor: compares every consumed word with the model queue
  always @(negedge CLK) begin
    if (RST) begin
      prevRedir = 1'b0;
      prevHeld  = 1'b0;
    end else begin
      if (prevRedir) checkOutput("redirect_clears_valid", {31'b0, bus.INSTR_VALID}, 32'd0);
      if (!bus.INSTR_VALID) checkOutput("idle_nop", bus.INSTR, NOP_INSTR);
      if (prevHeld) begin
        checkOutput("stall_hold_valid", {31'b0, bus.INSTR_VALID}, 32'd1);
        checkOutput("stall_hold_instr", bus.INSTR, heldInstr);
        checkOutput("stall_hold_pc", bus.INSTR_PC, heldPc);
      end
      if (bus.INSTR_VALID && !bus.STALL && !bus.REDIRECT) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_word: got pc %h instr %h want none", bus.INSTR_PC, bus.INSTR);
        end else begin
          expItem_t e;
          e = expQ.pop_front();
          checkOutput("instr_word", bus.INSTR, e.instr);
          checkOutput("instr_pc", bus.INSTR_PC, e.pc);
        end
        consumed++;
      end
      prevRedir = bus.REDIRECT;
      prevHeld  = bus.INSTR_VALID && bus.STALL && !bus.REDIRECT;
      heldInstr = bus.INSTR;
      heldPc    = bus.INSTR_PC;
    end
  end

  initial begin
    int w;
    bus.IMEM_GNT = 1'b0; bus.IMEM_RVALID = 1'b0; bus.IMEM_RDATA = '0;
    bus.REDIRECT = 1'b0; bus.REDIRECT_PC = '0; bus.STALL = 1'b0;
    gntPct = 100; minLat = 1; maxLat = 1; stallPct = 0; redirPct = 0; strayPct = 0;

    repeat (3) @(posedge CLK);
    #2;
    checkResetValues();
    @(negedge CLK);
    RST = 1'b0;

    // lw/sw/beq back to back with immediate grant and 1-cycle response
    repeat (7) applyStimulus();
    @(negedge CLK);
    #1;
    checkOutput("first_three_words", consumed, 32'd3);

    $display("[TB] random mixed traffic");
    gntPct = 60; minLat = 1; maxLat = 4; stallPct = 20; redirPct = 4; strayPct = 10;
    repeat (1500) applyStimulus();

    $display("[TB] stall-heavy traffic");
    stallPct = 50; redirPct = 2;
    repeat (800) applyStimulus();

    $display("[TB] reset during WAIT");
    gntPct = 100; minLat = 3; maxLat = 4; stallPct = 0; redirPct = 0; strayPct = 0;
    w = 0;
    while (outstanding && w < 20) begin applyStimulus(); w++; end
    while (!outstanding && w < 40) begin applyStimulus(); w++; end
    checkOutput("reset_phase_grant", {31'b0, outstanding}, 32'd1);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    bus.IMEM_GNT = 1'b0; bus.IMEM_RVALID = 1'b0; bus.REDIRECT = 1'b0; bus.STALL = 1'b0;
    #1;
    checkResetValues();
    outstanding = 1'b0;
    expQ.delete();
    modelPc = RESET_PC_DEFAULT;
    stallLeft = 0;
    @(negedge CLK);
    #1;
    RST = 1'b0;
    gntPct = 0; strayPct = 100;
    repeat (4) applyStimulus();
    strayPct = 0;
    applyStimulus();
    checkOutput("after_reset_addr", bus.IMEM_ADDR, RESET_PC_DEFAULT);
    checkOutput("after_reset_req", {31'b0, bus.IMEM_REQ}, 32'd1);
    checkOutput("after_reset_valid", {31'b0, bus.INSTR_VALID}, 32'd0);

    $display("[TB] random traffic after reset");
    gntPct = 70; minLat = 1; maxLat = 3; stallPct = 25; redirPct = 5; strayPct = 10;
    repeat (600) applyStimulus();

    gntPct = 0; stallPct = 0; redirPct = 0; strayPct = 0;
    w = 0;
    while ((outstanding || expQ.size() != 0) && w < 50) begin applyStimulus(); w++; end
    @(negedge CLK);
    #1;
    checkOutput("drain_queue_empty", expQ.size(), 32'd0);
    checkOutput("drain_idle", {31'b0, outstanding}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
